// File: rtl/aes_pkg.sv
// Shared types, sizes and the GF(2^8) doubling helper
// used by the AES-128 key-schedule sequencer.
package aes_pkg;

    localparam int AES_KEY_W     = 128;
    localparam int AES128_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        WAIT,
        DONE
    } ks_state_t;

    function automatic logic [7:0] xtime8(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_sched_ctrl_if.sv
// Request/result handshake between the key-schedule
// sequencer and the round-expansion datapath.
interface aes_key_sched_ctrl_if #(
    parameter int KEY_W = aes_pkg::AES_KEY_W
);

    logic             xp_req;
    logic [KEY_W-1:0] xp_key;
    logic [7:0]       xp_rcon;
    logic             xp_ack;
    logic [KEY_W-1:0] xp_result;

    modport master (
        output xp_req,
        output xp_key,
        output xp_rcon,
        input  xp_ack,
        input  xp_result
    );

    modport slave (
        input  xp_req,
        input  xp_key,
        input  xp_rcon,
        output xp_ack,
        output xp_result
    );

endinterface

// File: rtl/aes_rk_store.sv
// Round-key register file: one write port and one
// registered, range-checked read port.
module aes_rk_store #(
    parameter int KEY_W = 128,
    parameter int DEPTH = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [3:0]       waddr,
    input  logic [KEY_W-1:0] wdata,
    input  logic             rd,
    input  logic [3:0]       raddr,
    input  logic             rd_ok,
    output logic [KEY_W-1:0] rdata,
    output logic             rerr
);

    logic [KEY_W-1:0] mem [DEPTH];
    logic             hit;

    assign hit = rd_ok && (raddr <= 4'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata holds between reads; rerr is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
            rerr  <= 1'b0;
        end else if (rd) begin
            rdata <= hit ? mem[raddr] : '0;
            rerr  <= !hit;
        end else begin
            rerr  <= 1'b0;
        end
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion sequencer: loads the cipher key, runs
// ten datapath rounds with the proper Rcon and serves reads.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int KEY_W       = AES_KEY_W,
    parameter int NUM_ROUNDS  = AES128_ROUNDS,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    input  logic [KEY_W-1:0]     key_in,
    input  logic                 key_load,
    output logic                 busy,
    output logic                 keys_valid,
    output logic                 xp_timeout,
    aes_key_sched_ctrl_if.master xp,
    input  logic                 rk_rd,
    input  logic [3:0]           rk_addr,
    output logic [KEY_W-1:0]     rk_data,
    output logic                 rk_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    ks_state_t        state, state_n;
    logic [3:0]       round, round_n;
    logic [7:0]       rcon, rcon_n;
    logic             hold, hold_n;
    logic [TW-1:0]    tcnt, tcnt_n;
    logic [KEY_W-1:0] prev_key, prev_key_n;
    logic             tout, tout_n;
    logic             we;
    logic [3:0]       waddr;
    logic [KEY_W-1:0] wdata;
    logic             req;

    // hold marks the first WAIT cycle after a load, when xp_req stays low
    assign req        = (state == WAIT) && !hold;
    assign busy       = (state == WAIT) || (state == GAP);
    assign keys_valid = (state == DONE);
    assign xp_timeout = tout;

    assign xp.xp_req  = req;
    assign xp.xp_key  = (state == WAIT) ? prev_key : '0;
    assign xp.xp_rcon = (state == WAIT) ? rcon : 8'h00;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state    <= IDLE;
            round    <= 4'd0;
            rcon     <= 8'h01;
            hold     <= 1'b0;
            tcnt     <= '0;
            prev_key <= '0;
            tout     <= 1'b0;
        end else begin
            state    <= state_n;
            round    <= round_n;
            rcon     <= rcon_n;
            hold     <= hold_n;
            tcnt     <= tcnt_n;
            prev_key <= prev_key_n;
            tout     <= tout_n;
        end
    end

    always_comb begin
        state_n    = state;
        round_n    = round;
        rcon_n     = rcon;
        hold_n     = 1'b0;
        tcnt_n     = tcnt;
        prev_key_n = prev_key;
        tout_n     = tout;
        we         = 1'b0;
        waddr      = round;
        wdata      = xp.xp_result;

        unique case (state)
            IDLE: ;
            DONE: ;
            GAP: state_n = WAIT;
            WAIT: begin
                if (req) begin
                    if (xp.xp_ack) begin
                        we         = 1'b1;
                        prev_key_n = xp.xp_result;
                        tcnt_n     = '0;
                        if (round == 4'(NUM_ROUNDS)) begin
                            state_n = DONE;
                        end else begin
                            round_n = round + 4'd1;
                            rcon_n  = xtime8(rcon);
                            state_n = GAP;
                        end
                    end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        tout_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        tcnt_n = tcnt + 1'b1;
                    end
                end
            end
        endcase

        // a load restarts from any state and outranks a coincident ack
        if (key_load) begin
            state_n    = WAIT;
            round_n    = 4'd1;
            rcon_n     = 8'h01;
            hold_n     = 1'b1;
            tcnt_n     = '0;
            prev_key_n = key_in;
            tout_n     = 1'b0;
            we         = 1'b1;
            waddr      = 4'd0;
            wdata      = key_in;
        end
    end

    aes_rk_store #(
        .KEY_W (KEY_W),
        .DEPTH (NUM_ROUNDS + 1)
    ) u_store (
        .clk   (ACLK),
        .rst_n (ARESETN),
        .we    (we && ARESETN),
        .waddr (waddr),
        .wdata (wdata),
        .rd    (rk_rd),
        .raddr (rk_addr),
        .rd_ok (keys_valid),
        .rdata (rk_data),
        .rerr  (rk_err)
    );

endmodule
